// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the uart_tx round-robin arbiter:
//   arb_state_t  - FSM state encoding (IDLE=0, HDR=1, XFER=2, REL=3)
//   IDX_W        - requester index width, sized for the largest legal NUM_REQ (8)
//   HDR_TAG_DEF  - default upper nibble of the per-grant header byte
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } arb_state_t;

    localparam int         IDX_W       = 3;
    localparam logic [3:0] HDR_TAG_DEF = 4'hA;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick
// Combinational round-robin find-first-set. Searches i_req upward from
// i_last+1, wrapping at NUM_REQ, and returns the first set index.
// Ports:
//   i_req  [NUM_REQ-1:0] - request vector (inverted FIFO empty flags)
//   i_last [IDX_W-1:0]   - index granted last; search starts just above it
//   o_idx  [IDX_W-1:0]   - selected index (0 when nothing is requesting)
//   o_vld                - at least one request is set
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_vld
);

    // Walk the offsets from farthest to nearest so the nearest requester
    // after i_last is the one left standing.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                if (i_req[n] && (((int'(i_last) + k) % NUM_REQ) == n)) begin
                    o_idx = IDX_W'(n);
                    o_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte
// FIFOs. Toward uart_tx it looks like a single read FIFO (empty flag, read
// strobe, data one cycle after the strobe). A grant is held for at most
// BURST_LEN strobes, then released and re-arbitrated.
// Optional feature: define UART_ARB_HDR_EN to prefix every grant with one
// header byte {HDR_TAG, idx}; the HDR_TAG parameter exists only then.
// Ports:
//   s_clk, s_rst     - clock, synchronous active-high reset
//   req_empty        - per-requester FIFO empty flags
//   req_rd_en        - per-requester read strobes, one-hot or zero
//   req_rd_data      - per-requester read data, requester i at [8i+7:8i]
//   tx_empty         - empty flag toward uart_tx
//   tx_rd_en         - read strobe from uart_tx
//   tx_rd_data       - read data toward uart_tx
//   grant            - one-hot current owner, zero when idle
//   busy             - FSM is outside IDLE
//
// state | meaning
// IDLE  | no owner; pick next non-empty requester after last_idx
// HDR   | emit header byte for the new owner (UART_ARB_HDR_EN only)
// XFER  | pass owner's FIFO through to uart_tx, count strobes
// REL   | one-cycle release; data mux still held on the old owner
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 16
`ifdef UART_ARB_HDR_EN
    ,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
`endif
) (
    input  logic                   s_clk,
    input  logic                   s_rst,
    input  logic [NUM_REQ-1:0]     req_empty,
    output logic [NUM_REQ-1:0]     req_rd_en,
    input  logic [8*NUM_REQ-1:0]   req_rd_data,
    output logic                   tx_empty,
    input  logic                   tx_rd_en,
    output logic [7:0]             tx_rd_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [IDX_W-1:0]     r_last_idx;
    logic [7:0]           r_burst_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
`ifdef UART_ARB_HDR_EN
    logic                 r_hdr_sel;
`endif

    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_vld;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    logic                 w_sel_empty;
    logic [7:0]           w_sel_data;
    logic                 w_burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req  (~req_empty),
        .i_last (r_last_idx),
        .o_idx  (w_pick_idx),
        .o_vld  (w_pick_vld)
    );

    assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_burst_end   = (r_burst_cnt == 8'(BURST_LEN - 1));

    // Owner's empty flag and data slice; compare-based select keeps the
    // index width independent of NUM_REQ.
    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt_idx == IDX_W'(i)) begin
                w_sel_empty = req_empty[i];
                w_sel_data  = req_rd_data[8*i +: 8];
            end
        end
    end

    // Zero-latency strobe pass-through, only while transferring.
    always_comb begin
        req_rd_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rd_en[i] = (r_state == ST_XFER) && tx_rd_en && (r_gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        case (r_state)
            ST_HDR:  tx_empty = 1'b0;
            ST_XFER: tx_empty = w_sel_empty;
            default: tx_empty = 1'b1;
        endcase
    end

`ifdef UART_ARB_HDR_EN
    assign tx_rd_data = r_hdr_sel ? {HDR_TAG, 1'b0, r_gnt_idx} : w_sel_data;
`else
    assign tx_rd_data = w_sel_data;
`endif

    assign grant = r_grant;
    assign busy  = r_busy;

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state     <= ST_IDLE;
            r_gnt_idx   <= '0;
            r_last_idx  <= IDX_W'(NUM_REQ - 1);
            r_burst_cnt <= 8'h00;
            r_grant     <= '0;
            r_busy      <= 1'b0;
`ifdef UART_ARB_HDR_EN
            r_hdr_sel   <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_HDR_EN
            r_hdr_sel <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt_idx   <= w_pick_idx;
                        r_burst_cnt <= 8'h00;
                        r_grant     <= w_pick_onehot;
                        r_busy      <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        r_state     <= ST_HDR;
`else
                        r_state     <= ST_XFER;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                ST_HDR: begin
                    if (tx_rd_en) begin
                        r_hdr_sel <= 1'b1;
                        r_state   <= ST_XFER;
                    end
                end
`endif
                ST_XFER: begin
                    // A strobe coinciding with the FIFO draining still counts;
                    // the empty release is taken on the following cycle.
                    if (tx_rd_en) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                        if (w_burst_end) begin
                            r_state <= ST_REL;
                        end
                    end else if (w_sel_empty) begin
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    r_last_idx <= r_gnt_idx;
                    r_grant    <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic [3:0]  req_empty;
    logic [3:0]  req_rd_en;
    logic [31:0] req_rd_data;
    logic        tx_empty;
    logic        tx_rd_en = 1'b0;
    logic [7:0]  tx_rd_data;
    logic [3:0]  grant;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_arb #(
        .NUM_REQ   (4),
        .BURST_LEN (2)
    ) dut (
        .s_clk       (s_clk),
        .s_rst       (s_rst),
        .req_empty   (req_empty),
        .req_rd_en   (req_rd_en),
        .req_rd_data (req_rd_data),
        .tx_empty    (tx_empty),
        .tx_rd_en    (tx_rd_en),
        .tx_rd_data  (tx_rd_data),
        .grant       (grant),
        .busy        (busy)
    );

    always #10 s_clk = ~s_clk;

    // Requester FIFO models: data valid the cycle after the read strobe.
    logic [7:0] mem [4][64];
    int         wr_ptr [4] = '{0, 0, 0, 0};
    int         rd_ptr [4] = '{0, 0, 0, 0};
    logic [7:0] fifo_out [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    always_comb begin
        req_empty   = '1;
        req_rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_empty[i]          = (rd_ptr[i] == wr_ptr[i]);
            req_rd_data[8*i +: 8] = fifo_out[i];
        end
    end

    always @(posedge s_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_rd_en[i]) begin
                fifo_out[i] <= mem[i][rd_ptr[i] % 64];
                rd_ptr[i]   <= rd_ptr[i] + 1;
            end
        end
    end

    task automatic push(input int idx, input logic [7:0] d);
        mem[idx][wr_ptr[idx] % 64] = d;
        wr_ptr[idx] = wr_ptr[idx] + 1;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        @(negedge s_clk);
        @(negedge s_clk);
        s_rst = 1'b0;
    endtask

    // uart_tx model: wait for non-empty, strobe one cycle, take data next cycle.
    task automatic pull(output logic [7:0] b, output logic [3:0] rd, output logic [3:0] g);
        int n = 0;
        while (tx_empty !== 1'b0 && n < 40) begin
            @(negedge s_clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL pull_timeout tx_empty=%b required 0", tx_empty);
        end
        tx_rd_en = 1'b1;
        #1;
        rd = req_rd_en;
        g  = grant;
        @(negedge s_clk);
        tx_rd_en = 1'b0;
        b = tx_rd_data;
    endtask

    // With the header feature each grant starts with {4'hA, idx}; no FIFO read.
    task automatic hdr_if_en(input int idx);
`ifdef UART_ARB_HDR_EN
        logic [7:0] b;
        logic [3:0] rd, g;
        pull(b, rd, g);
        checks++;
        if (b !== {4'hA, 4'(idx)}) begin
            failures++;
            $display("FAIL hdr_byte got %h exp %h", b, {4'hA, 4'(idx)});
        end
        checks++;
        if (rd !== 4'b0000) begin
            failures++;
            $display("FAIL hdr_rd_en got %b exp 0000", rd);
        end
`endif
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        @(negedge s_clk);
        @(negedge s_clk);
        checks++;
        if (tx_empty !== 1'b1) begin failures++; $display("FAIL reset_tx_empty got %b exp 1", tx_empty); end
        checks++;
        if (req_rd_en !== 4'b0000) begin failures++; $display("FAIL reset_rd_en got %b exp 0000", req_rd_en); end
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got %b exp 0000", grant); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        s_rst = 1'b0;
    endtask

    task automatic test_single_source();
        logic [7:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] b;
        logic [3:0] rd, g;
        int n;
        do_reset();
        for (int j = 0; j < 3; j++) push(1, exp_b[j]);
        for (int j = 0; j < 3; j++) begin
            if (j % 2 == 0) hdr_if_en(1);
            pull(b, rd, g);
            checks++;
            if (b !== exp_b[j]) begin failures++; $display("FAIL single_byte[%0d] got %h exp %h", j, b, exp_b[j]); end
            checks++;
            if (g !== 4'b0010) begin failures++; $display("FAIL single_grant[%0d] got %b exp 0010", j, g); end
            checks++;
            if (rd !== 4'b0010) begin failures++; $display("FAIL single_rd_en[%0d] got %b exp 0010", j, rd); end
        end
        n = 0;
        while (busy !== 1'b0 && n < 10) begin
            @(negedge s_clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || grant !== 4'b0000 || tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL single_release busy=%b grant=%b tx_empty=%b exp 0 0000 1", busy, grant, tx_empty);
        end
    endtask

    task automatic test_burst_limit();
        logic [7:0] exp_b [8] = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h03, 8'h04, 8'h23, 8'h24};
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0100};
        logic [7:0] b;
        logic [3:0] rd, g;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            push(0, 8'h01 + 8'(j));
            push(2, 8'h21 + 8'(j));
        end
        for (int p = 0; p < 8; p++) begin
            if (p % 2 == 0) hdr_if_en(exp_g[p] == 4'b0001 ? 0 : 2);
            pull(b, rd, g);
            checks++;
            if (b !== exp_b[p]) begin failures++; $display("FAIL burst_byte[%0d] got %h exp %h", p, b, exp_b[p]); end
            checks++;
            if (g !== exp_g[p]) begin failures++; $display("FAIL burst_grant[%0d] got %b exp %b", p, g, exp_g[p]); end
            if (p % 2 == 1) begin
                checks++;
                if (tx_empty !== 1'b1) begin failures++; $display("FAIL burst_release[%0d] tx_empty got %b exp 1", p, tx_empty); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [7:0] b, e;
        logic [3:0] rd, g, eg;
        int k, j;
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) push(r, {4'(r), 4'(q)});
        // Two bytes per grant, owners 0,1,2,3,0,1,2,3.
        for (int p = 0; p < 16; p++) begin
            k  = (p / 2) % 4;
            j  = (p / 8) * 2 + (p % 2);
            e  = {4'(k), 4'(j)};
            eg = 4'b0001 << k;
            if (p % 2 == 0) hdr_if_en(k);
            pull(b, rd, g);
            checks++;
            if (b !== e) begin failures++; $display("FAIL fair_byte[%0d] got %h exp %h", p, b, e); end
            checks++;
            if (g !== eg || rd !== eg) begin
                failures++;
                $display("FAIL fair_grant[%0d] grant=%b rd_en=%b exp %b", p, g, rd, eg);
            end
            if (p % 2 == 1) begin
                checks++;
                if (tx_empty !== 1'b1) begin failures++; $display("FAIL fair_release[%0d] tx_empty got %b exp 1", p, tx_empty); end
            end
        end
    endtask

    task automatic test_stray_strobe();
        do_reset();
        tx_rd_en = 1'b1;
        #1;
        checks++;
        if (req_rd_en !== 4'b0000) begin failures++; $display("FAIL stray_rd_en got %b exp 0000", req_rd_en); end
        @(negedge s_clk);
        tx_rd_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant !== 4'b0000 || tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL stray_state busy=%b grant=%b tx_empty=%b exp 0 0000 1", busy, grant, tx_empty);
        end
        checks++;
        if (dut.r_burst_cnt !== 8'h00) begin failures++; $display("FAIL stray_burst_cnt got %h exp 00", dut.r_burst_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] b;
        logic [3:0] rd, g;
        do_reset();
        for (int j = 0; j < 4; j++) push(2, 8'h41 + 8'(j));
        hdr_if_en(2);
        pull(b, rd, g);
        checks++;
        if (b !== 8'h41 || g !== 4'b0100) begin
            failures++;
            $display("FAIL mid_first byte=%h grant=%b exp 41 0100", b, g);
        end
        s_rst = 1'b1;
        @(negedge s_clk);
        s_rst = 1'b0;
        push(0, 8'h05);
        tx_rd_en = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || tx_empty !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset grant=%b tx_empty=%b busy=%b exp 0000 1 0", grant, tx_empty, busy);
        end
        checks++;
        if (req_rd_en !== 4'b0000) begin failures++; $display("FAIL mid_reset_rd_en got %b exp 0000", req_rd_en); end
        @(negedge s_clk);
        tx_rd_en = 1'b0;
        hdr_if_en(0);
        pull(b, rd, g);
        checks++;
        if (b !== 8'h05 || g !== 4'b0001) begin
            failures++;
            $display("FAIL mid_rearb byte=%h grant=%b exp 05 0001", b, g);
        end
    endtask

`ifdef UART_ARB_HDR_EN
    task automatic test_header();
        logic [7:0] b;
        logic [3:0] rd, g;
        do_reset();
        push(3, 8'h5C);
        pull(b, rd, g);
        checks++;
        if (b !== 8'hA3) begin failures++; $display("FAIL hdr3_byte got %h exp a3", b); end
        checks++;
        if (rd !== 4'b0000) begin failures++; $display("FAIL hdr3_rd_en got %b exp 0000", rd); end
        pull(b, rd, g);
        checks++;
        if (b !== 8'h5C || rd !== 4'b1000) begin
            failures++;
            $display("FAIL hdr3_payload byte=%h rd_en=%b exp 5c 1000", b, rd);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge s_clk);
        test_reset();
        test_single_source();
        test_burst_limit();
        test_fairness();
        test_stray_strobe();
`ifdef UART_ARB_HDR_EN
        test_header();
`endif
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
